// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate_sweep self-test block: op codes, sequencer
// states, the NAND primitive and the helpers that walk the enabled-op mask.
package gate_sweep_pkg;

  localparam int NUM_OPS = 8;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_NAND = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // The single primitive every logic function in nand_alu is built from.
  function automatic logic nand2(input logic a, input logic b);
    return ~(a & b);
  endfunction

  // Lowest enabled op code; only meaningful when mask is nonzero.
  function automatic op_e first_op(input logic [NUM_OPS-1:0] mask);
    op_e res;
    res = OP_AND;
    for (int k = NUM_OPS - 1; k >= 0; k--) begin
      if (mask[k]) res = op_e'(k[2:0]);
    end
    return res;
  endfunction

  // True when some op with a higher code than cur is enabled.
  function automatic logic has_next(input logic [NUM_OPS-1:0] mask, input op_e cur);
    logic found;
    found = 1'b0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (k > int'(cur) && mask[k]) found = 1'b1;
    end
    return found;
  endfunction

  // Next enabled op code above cur; returns cur when there is none.
  function automatic op_e next_op(input logic [NUM_OPS-1:0] mask, input op_e cur);
    op_e nxt;
    nxt = cur;
    for (int k = NUM_OPS - 1; k >= 0; k--) begin
      if (k > int'(cur) && mask[k]) nxt = op_e'(k[2:0]);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gate_sweep_nand_alu.sv
// nand_alu: purely combinational WIDTH-bit logic unit. Every logic function is
// a per-bit chain of two-input NAND gates; the op code only picks which chain
// output reaches the result.
module nand_alu
  import gate_sweep_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] res
);

  logic [WIDTH-1:0] n_xy;   // nand(x,y)
  logic [WIDTH-1:0] n_x;    // not x
  logic [WIDTH-1:0] n_y;    // not y
  logic [WIDTH-1:0] f_and;
  logic [WIDTH-1:0] f_or;
  logic [WIDTH-1:0] f_nor;
  logic [WIDTH-1:0] t_x;    // nand(x, nand(x,y))
  logic [WIDTH-1:0] t_y;    // nand(y, nand(x,y))
  logic [WIDTH-1:0] f_xor;
  logic [WIDTH-1:0] f_xnor;
  logic [WIDTH-1:0] f_pass;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign n_xy[i]   = nand2(x[i], y[i]);
    assign n_x[i]    = nand2(x[i], x[i]);
    assign n_y[i]    = nand2(y[i], y[i]);
    assign f_and[i]  = nand2(n_xy[i], n_xy[i]);
    assign f_or[i]   = nand2(n_x[i], n_y[i]);
    assign f_nor[i]  = nand2(f_or[i], f_or[i]);
    assign t_x[i]    = nand2(x[i], n_xy[i]);
    assign t_y[i]    = nand2(y[i], n_xy[i]);
    assign f_xor[i]  = nand2(t_x[i], t_y[i]);
    assign f_xnor[i] = nand2(f_xor[i], f_xor[i]);
    assign f_pass[i] = nand2(n_x[i], n_x[i]);
  end

  // Select the chain output for the requested op.
  always_comb begin
    res = '0;
    case (op)
      OP_AND:  res = f_and;
      OP_NAND: res = n_xy;
      OP_OR:   res = f_or;
      OP_NOR:  res = f_nor;
      OP_XOR:  res = f_xor;
      OP_XNOR: res = f_xnor;
      OP_NOT:  res = n_x;
      OP_PASS: res = f_pass;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/gate_sweep.sv
// gate_sweep: bring-up self-test for the NAND gate library. A sequencer walks
// every {y,x} operand pair through each enabled op, the NAND-built result and a
// native-operator reference are registered in stage 1 and compared in stage 2.
// Optional first-failure log: define GATE_SWEEP_FAILLOG_EN.
//
// Handshake: i_start is a level sampled only while IDLE (i_op_mask is latched
// in that same cycle); once accepted o_busy covers RUN and DRAIN and o_done is a
// single-cycle pulse in DONE, with o_pass/o_err_cnt valid from that cycle until
// the next accepted start. i_start outside IDLE is ignored.
module gate_sweep
  import gate_sweep_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int ERR_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [7:0]       i_op_mask,
  input  logic             i_fault_inj,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [2:0]       o_op,
  output logic [WIDTH-1:0] o_x,
  output logic [WIDTH-1:0] o_y,
  output logic [WIDTH-1:0] o_res,
`ifdef GATE_SWEEP_FAILLOG_EN
  output logic             o_fail_vld,
  output logic [2:0]       o_fail_op,
  output logic [WIDTH-1:0] o_fail_x,
  output logic [WIDTH-1:0] o_fail_y,
`endif
  output state_e           o_state
);

  localparam int IDX_W = 2 * WIDTH;

  state_e           state;
  logic [7:0]       mask_q;
  op_e              op_q;
  logic [IDX_W-1:0] idx_q;      // {y,x}, x in the LSBs
  logic             drain_cnt;

  logic             s1_vld;
  logic [WIDTH-1:0] s1_res;
  logic [WIDTH-1:0] s1_ref;
  logic [WIDTH-1:0] s1_res_f;   // stage-1 result after optional fault flip

  logic [WIDTH-1:0] cur_x;
  logic [WIDTH-1:0] cur_y;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] ref_res;
  logic             accept;
  logic             mismatch;

  assign cur_x    = idx_q[WIDTH-1:0];
  assign cur_y    = idx_q[IDX_W-1:WIDTH];
  assign accept   = (state == IDLE) && i_start;
  // The fault flips bit 0 of whatever vector sits in stage 1 this cycle.
  assign s1_res_f = s1_res ^ WIDTH'(i_fault_inj & s1_vld);
  assign mismatch = s1_vld && (s1_res_f != s1_ref);

  assign o_op    = op_q;
  assign o_x     = cur_x;
  assign o_y     = cur_y;
  assign o_res   = s1_res_f;
  assign o_state = state;

  nand_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op  (op_q),
    .x   (cur_x),
    .y   (cur_y),
    .res (alu_res)
  );

  // Native-operator reference for the vector issued in stage 0.
  always_comb begin
    ref_res = '0;
    case (op_q)
      OP_AND:  ref_res = cur_x & cur_y;
      OP_NAND: ref_res = ~(cur_x & cur_y);
      OP_OR:   ref_res = cur_x | cur_y;
      OP_NOR:  ref_res = ~(cur_x | cur_y);
      OP_XOR:  ref_res = cur_x ^ cur_y;
      OP_XNOR: ref_res = ~(cur_x ^ cur_y);
      OP_NOT:  ref_res = ~cur_x;
      OP_PASS: ref_res = cur_x;
      default: ref_res = '0;
    endcase
  end

  // Sequencer FSM: issues one vector per RUN cycle, drains, pulses done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      mask_q    <= '0;
      op_q      <= OP_AND;
      idx_q     <= '0;
      drain_cnt <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_pass    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            mask_q <= i_op_mask;
            o_pass <= 1'b0;
            if (i_op_mask != 8'd0) begin
              state  <= RUN;
              op_q   <= first_op(i_op_mask);
              idx_q  <= '0;
              o_busy <= 1'b1;
            end else begin
              // Empty mask: nothing to check, so the sweep trivially passes.
              state  <= DONE;
              o_done <= 1'b1;
              o_pass <= 1'b1;
            end
          end
        end
        RUN: begin
          if (idx_q == {IDX_W{1'b1}}) begin
            idx_q <= '0;
            if (has_next(mask_q, op_q)) begin
              op_q <= next_op(mask_q, op_q);
            end else begin
              state     <= DRAIN;
              drain_cnt <= 1'b0;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            // Last compare has landed in o_err_cnt by now.
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            o_pass <= (o_err_cnt == '0);
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: register the NAND-unit result and the reference result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld <= 1'b0;
      s1_res <= '0;
      s1_ref <= '0;
    end else begin
      s1_vld <= (state == RUN);
      s1_res <= alu_res;
      s1_ref <= ref_res;
    end
  end

  // Stage 2: count mismatches, saturating at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_cnt <= '0;
    end else if (accept) begin
      o_err_cnt <= '0;
    end else if (mismatch && (o_err_cnt != {ERR_W{1'b1}})) begin
      o_err_cnt <= o_err_cnt + 1'b1;
    end
  end

`ifdef GATE_SWEEP_FAILLOG_EN
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_y;

  // Carry the stage-0 vector alongside its results for the failure log.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_op <= '0;
      s1_x  <= '0;
      s1_y  <= '0;
    end else begin
      s1_op <= op_q;
      s1_x  <= cur_x;
      s1_y  <= cur_y;
    end
  end

  // Capture only the first mismatching vector of a sweep.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fail_vld <= 1'b0;
      o_fail_op  <= '0;
      o_fail_x   <= '0;
      o_fail_y   <= '0;
    end else if (accept) begin
      o_fail_vld <= 1'b0;
      o_fail_op  <= '0;
      o_fail_x   <= '0;
      o_fail_y   <= '0;
    end else if (mismatch && !o_fail_vld) begin
      o_fail_vld <= 1'b1;
      o_fail_op  <= s1_op;
      o_fail_x   <= s1_x;
      o_fail_y   <= s1_y;
    end
  end
`endif

endmodule

// File: tb/tb_gate_sweep.sv
// Bench for gate_sweep: three instances (WIDTH=2/ERR_W=16, WIDTH=1, ERR_W=3)
// share clock, reset, mask and fault; a selector routes one instance's outputs
// to the checker. Expectations come from a vector-list model of the sweep.
module tb_gate_sweep;
  import gate_sweep_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [2:0] start_v;
  logic [7:0] op_mask;
  logic       fault_inj;
  int         sel;

  int checks;
  int errors;

  // Instance A: WIDTH=2, ERR_W=16
  logic a_busy, a_done, a_pass;
  logic [15:0] a_err;
  logic [2:0] a_op;
  logic [1:0] a_x, a_y, a_res;
  state_e a_state;
  // Instance B: WIDTH=1, ERR_W=16
  logic b_busy, b_done, b_pass;
  logic [15:0] b_err;
  logic [2:0] b_op;
  logic b_x, b_y, b_res;
  state_e b_state;
  // Instance C: WIDTH=2, ERR_W=3
  logic c_busy, c_done, c_pass;
  logic [2:0] c_err;
  logic [2:0] c_op;
  logic [1:0] c_x, c_y, c_res;
  state_e c_state;

`ifdef GATE_SWEEP_FAILLOG_EN
  logic a_fvld, b_fvld, c_fvld;
  logic [2:0] a_fop, b_fop, c_fop;
  logic [1:0] a_fx, a_fy, c_fx, c_fy;
  logic b_fx, b_fy;
`endif

  gate_sweep #(.WIDTH(2), .ERR_W(16)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_v[0]), .i_op_mask(op_mask),
    .i_fault_inj(fault_inj), .o_busy(a_busy), .o_done(a_done), .o_pass(a_pass),
    .o_err_cnt(a_err), .o_op(a_op), .o_x(a_x), .o_y(a_y), .o_res(a_res),
`ifdef GATE_SWEEP_FAILLOG_EN
    .o_fail_vld(a_fvld), .o_fail_op(a_fop), .o_fail_x(a_fx), .o_fail_y(a_fy),
`endif
    .o_state(a_state)
  );

  gate_sweep #(.WIDTH(1), .ERR_W(16)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_v[1]), .i_op_mask(op_mask),
    .i_fault_inj(fault_inj), .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass),
    .o_err_cnt(b_err), .o_op(b_op), .o_x(b_x), .o_y(b_y), .o_res(b_res),
`ifdef GATE_SWEEP_FAILLOG_EN
    .o_fail_vld(b_fvld), .o_fail_op(b_fop), .o_fail_x(b_fx), .o_fail_y(b_fy),
`endif
    .o_state(b_state)
  );

  gate_sweep #(.WIDTH(2), .ERR_W(3)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_v[2]), .i_op_mask(op_mask),
    .i_fault_inj(fault_inj), .o_busy(c_busy), .o_done(c_done), .o_pass(c_pass),
    .o_err_cnt(c_err), .o_op(c_op), .o_x(c_x), .o_y(c_y), .o_res(c_res),
`ifdef GATE_SWEEP_FAILLOG_EN
    .o_fail_vld(c_fvld), .o_fail_op(c_fop), .o_fail_x(c_fx), .o_fail_y(c_fy),
`endif
    .o_state(c_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- output selector ----------------
  logic m_busy, m_done, m_pass;
  logic [15:0] m_err;
  logic [2:0] m_op;
  logic [1:0] m_x, m_y, m_res;
  state_e m_state;

  always_comb begin
    m_busy = a_busy; m_done = a_done; m_pass = a_pass; m_err = a_err;
    m_op = a_op; m_x = a_x; m_y = a_y; m_res = a_res; m_state = a_state;
    if (sel == 1) begin
      m_busy = b_busy; m_done = b_done; m_pass = b_pass; m_err = b_err;
      m_op = b_op; m_x = {1'b0, b_x}; m_y = {1'b0, b_y}; m_res = {1'b0, b_res};
      m_state = b_state;
    end else if (sel == 2) begin
      m_busy = c_busy; m_done = c_done; m_pass = c_pass; m_err = {13'd0, c_err};
      m_op = c_op; m_x = c_x; m_y = c_y; m_res = c_res; m_state = c_state;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural truth of each op on w-bit operands.
  function automatic int op_fn(input int op, input int x, input int y, input int w);
    int m;
    m = (1 << w) - 1;
    case (op)
      0: return x & y;
      1: return ~(x & y) & m;
      2: return x | y;
      3: return ~(x | y) & m;
      4: return x ^ y;
      5: return ~(x ^ y) & m;
      6: return ~x & m;
      default: return x;
    endcase
  endfunction

  function automatic int popcount8(input logic [7:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) if (v[i]) n++;
    return n;
  endfunction

  // Runs one sweep on instance s and checks every cycle against the expected
  // vector list, pipeline result, error count and busy window.
  task automatic run_sweep(input int s, input logic [7:0] mask, input logic fault,
                           input bit repulse, output int done_cyc,
                           output int err_done, output int pass_done);
    int w, v, sat, last, exp_err, exp_res, fin;
    int q_op[$];
    int q_x[$];
    int q_y[$];
    w   = (s == 1) ? 1 : 2;
    v   = 1 << (2 * w);
    sat = (s == 2) ? 7 : 65535;
    for (int op = 0; op < 8; op++) begin
      if (mask[op]) begin
        for (int i = 0; i < v; i++) begin
          q_op.push_back(op);
          q_x.push_back(i % (1 << w));
          q_y.push_back(i >> w);
        end
      end
    end
    last      = q_op.size();
    done_cyc  = -1;
    err_done  = -1;
    pass_done = -1;
    @(negedge clk);
    sel        = s;
    op_mask    = mask;
    fault_inj  = fault;
    start_v[s] = 1'b1;
    @(posedge clk);
    #1;
    start_v[s] = 1'b0;
    op_mask    = 8'($urandom_range(0, 255));   // must not matter after start
    for (int c = 1; c <= last + 10; c++) begin
      if (repulse && c == 5) start_v[s] = 1'b1;
      if (repulse && c == 6) start_v[s] = 1'b0;
      if (c <= last) begin
        chk("op", int'(m_op), q_op[c-1]);
        chk("x", int'(m_x), q_x[c-1]);
        chk("y", int'(m_y), q_y[c-1]);
      end
      if (c >= 2 && c <= last + 1) begin
        exp_res = op_fn(q_op[c-2], q_x[c-2], q_y[c-2], w) ^ int'(fault);
        chk("res", int'(m_res), exp_res);
      end
      fin = c - 2;
      if (fin < 0) fin = 0;
      if (fin > last) fin = last;
      exp_err = fault ? ((fin > sat) ? sat : fin) : 0;
      chk("err_cnt", int'(m_err), exp_err);
      chk("busy", int'(m_busy), (last > 0 && c <= last + 2) ? 1 : 0);
      if (m_done) begin
        done_cyc  = c;
        err_done  = int'(m_err);
        pass_done = int'(m_pass);
        break;
      end
      @(posedge clk);
      #1;
    end
    if (done_cyc < 0) begin
      chk("done_timeout", 0, 1);
    end else begin
      @(posedge clk);
      #1;
      chk("done_pulse_len", int'(m_done), 0);
      chk("state_after_done", int'(m_state), int'(IDLE));
      chk("pass_hold", int'(m_pass), pass_done);
    end
  endtask

  typedef struct {
    logic [7:0] mask;
    logic       fault;
    int         exp_done;
    int         exp_err;
    int         exp_pass;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int dc, ed, pd, k, v;
    checks    = 0;
    errors    = 0;
    sel       = 0;
    start_v   = 3'b000;
    op_mask   = 8'h00;
    fault_inj = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state of instance A.
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_done", int'(a_done), 0);
    chk("rst_pass", int'(a_pass), 0);
    chk("rst_err", int'(a_err), 0);
    chk("rst_op", int'(a_op), 0);
    chk("rst_x", int'(a_x), 0);
    chk("rst_y", int'(a_y), 0);
    chk("rst_res", int'(a_res), 0);
    chk("rst_state", int'(a_state), int'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed table for WIDTH=2 (V=16): done = K*16+3, or 1 when K=0.
    tbl[0] = '{8'hFF, 1'b0, 131, 0, 1};
    tbl[1] = '{8'h01, 1'b1, 19, 16, 0};
    tbl[2] = '{8'h00, 1'b0, 1, 0, 1};
    tbl[3] = '{8'h80, 1'b0, 19, 0, 1};
    tbl[4] = '{8'h0C, 1'b1, 35, 32, 0};
    tbl[5] = '{8'hAA, 1'b1, 67, 64, 0};
    for (int i = 0; i < 6; i++) begin
      run_sweep(0, tbl[i].mask, tbl[i].fault, 1'b0, dc, ed, pd);
      chk("tbl_done_cyc", dc, tbl[i].exp_done);
      chk("tbl_err", ed, tbl[i].exp_err);
      chk("tbl_pass", pd, tbl[i].exp_pass);
`ifdef GATE_SWEEP_FAILLOG_EN
      chk("tbl_fail_vld", int'(a_fvld), (tbl[i].fault && tbl[i].mask != 0) ? 1 : 0);
      if (tbl[i].fault && tbl[i].mask != 0) begin
        chk("tbl_fail_op", int'(a_fop), int'(first_op(tbl[i].mask)));
        chk("tbl_fail_x", int'(a_fx), 0);
        chk("tbl_fail_y", int'(a_fy), 0);
      end
`endif
    end

    // WIDTH=1, ops 2 and 5: 8 vectors back to back, done at cycle 11.
    run_sweep(1, 8'h24, 1'b0, 1'b0, dc, ed, pd);
    chk("w1_done_cyc", dc, 11);
    chk("w1_pass", pd, 1);

    // Start re-pulsed during RUN is ignored.
    run_sweep(0, 8'hFF, 1'b0, 1'b1, dc, ed, pd);
    chk("repulse_done_cyc", dc, 131);
    chk("repulse_pass", pd, 1);

    // ERR_W=3 saturates at 7.
    run_sweep(2, 8'hFF, 1'b1, 1'b0, dc, ed, pd);
    chk("sat_done_cyc", dc, 131);
    chk("sat_err", ed, 7);
    chk("sat_pass", pd, 0);

    // Reset at cycle 10 of a sweep aborts it with no done pulse.
    @(negedge clk);
    sel        = 0;
    fault_inj  = 1'b0;
    op_mask    = 8'hFF;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(a_busy), 0);
    chk("abort_done", int'(a_done), 0);
    chk("abort_pass", int'(a_pass), 0);
    chk("abort_err", int'(a_err), 0);
    chk("abort_op", int'(a_op), 0);
    chk("abort_x", int'(a_x), 0);
    chk("abort_y", int'(a_y), 0);
    chk("abort_res", int'(a_res), 0);
    chk("abort_state", int'(a_state), int'(IDLE));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", int'(a_done), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, 8'hFF, 1'b0, 1'b0, dc, ed, pd);
    chk("post_rst_done_cyc", dc, 131);
    chk("post_rst_pass", pd, 1);

    // Random masks and fault levels against the sweep-length model.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] rm;
      logic       rf;
      rm = 8'($urandom_range(0, 255));
      rf = 1'($urandom_range(0, 1));
      k  = popcount8(rm);
      v  = 16;
      run_sweep(0, rm, rf, 1'b0, dc, ed, pd);
      chk("rnd_done_cyc", dc, (k > 0) ? k * v + 3 : 1);
      chk("rnd_err", ed, rf ? k * v : 0);
      chk("rnd_pass", pd, (rf && k > 0) ? 0 : 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_sweep.md
# gate_sweep

Self-checking, parametrised successor to the NAND-built gate library. It contains a WIDTH-bit logic unit built only from NAND primitives. A sequencer sweeps every operand combination through each selected operation and compares each registered result with a native-operator reference model. It counts mismatches and reports pass/fail with a start/done handshake, and is used as a synthesizable bring-up self-test beside the gate library.

## Interface
- WIDTH, 2: operand width in bits; 1..6.
- ERR_W, 16: error counter width.
- i_clk  in  1  clock; all state is updated on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  request a sweep; sampled only in IDLE.
- i_op_mask  in  8  bit k enables op k; sampled with i_start.
- i_fault_inj  in  1  when high, inverts bit 0 of the NAND-unit result in pipeline stage 1.
- o_busy  out  1  high in RUN and DRAIN.
- o_done  out  1  one-cycle pulse at sweep end.
- o_pass  out  1  high when the last completed sweep had zero errors.
- o_err_cnt  out  ERR_W  mismatch count; saturating.
- o_op  out  3  op currently issued in stage 0.
- o_x, o_y  out  WIDTH  operands currently issued in stage 0.
- o_res  out  WIDTH  registered NAND-unit result (stage 1).

## Operation
- Op codes: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT x, 7 PASS x.
- Ops 6 and 7 ignore y but still sweep all y values, so every op has the same length.
- Vectors per op: V = 2^(2·WIDTH). Sweep order: {y,x} counts up from 0 to V-1, with x as the LSBs.
- Ops run in ascending code order; disabled ops are skipped with no bubble.
- FSM states and transitions:
  - IDLE: on i_start, if the mask is nonzero go to RUN, else go to DONE. The mask is latched at this point.
  - RUN: issues one vector per cycle. After the last vector of the last enabled op, go to DRAIN.
  - DRAIN: 2 cycles, lets the pipeline empty.
  - DONE: 1 cycle, o_done=1, then back to IDLE.
- Pipeline stages:
  - Stage 0: issue op/x/y.
  - Stage 1: register the NAND-unit result and the reference result.
  - Stage 2: compare; on mismatch, err_cnt increments.
- o_err_cnt saturates at 2^ERR_W-1 and does not wrap.
- On an accepted start, err_cnt is cleared and o_pass is cleared.
- o_pass is set in the DONE cycle if err_cnt==0 and holds until the next accepted start.
- i_start in any state other than IDLE is ignored. i_op_mask changes during a sweep have no effect.
- i_fault_inj is sampled every cycle. It affects only vectors that are in stage 1 during that cycle.
- Reset values: state IDLE; all outputs 0, including o_pass, o_err_cnt, o_op, o_x, o_y, o_res.
- Reset asserted mid-sweep aborts the sweep immediately. No o_done pulse is produced.

## Timing
- i_start is sampled high at cycle 0, with K = number of enabled ops:
  - K>0: RUN covers cycles 1..K·V, DRAIN covers K·V+1..K·V+2, and o_done=1 at cycle K·V+3.
  - K=0: o_done=1 at cycle 1, with o_pass=1 and o_err_cnt=0.
- A vector issued at cycle n appears on o_res at n+1. Its mismatch is visible on o_err_cnt at n+2.
- o_busy rises at cycle 1 and falls in the DONE cycle.
- A new i_start is accepted no earlier than the cycle after DONE.
- Throughput: one vector per clock with no stalls.

## Configuration
- GATE_SWEEP_FAILLOG_EN defined adds outputs o_fail_vld (1), o_fail_op (3), o_fail_x (WIDTH) and o_fail_y (WIDTH).
  - These capture the first mismatching vector of the sweep and hold it until the next accepted start.
  - They reset to 0.
- GATE_SWEEP_FAILLOG_EN undefined: these ports and their registers do not exist. All other behaviour is identical.

## Structure
- gate_sweep_pkg holds the shared definitions:
  - op_e: 3-bit op enum.
  - state_e: IDLE, RUN, DRAIN, DONE.
  - NUM_OPS = 8.
  - Function next_op(mask, cur), returning the next enabled op code.
- Sub-module nand_alu, parameter WIDTH: purely combinational. It computes op(x,y) using only NAND gates, with each bit built as a per-bit nand/not/and/or/xor chain.
- The reference model uses native operators inside gate_sweep.

## Test plan
- WIDTH=2, mask=0xFF, no fault → o_done at cycle 131; o_pass=1, o_err_cnt=0.
- WIDTH=2, mask=0x01, i_fault_inj held high → o_done at cycle 19; o_err_cnt=16, o_pass=0. With FAILLOG: fail_op=0, fail_x=0, fail_y=0.
- mask=0x00 → o_done at cycle 1, o_pass=1; o_busy never asserts.
- WIDTH=1, mask=0x24 (ops 2 and 5) → o_op sequence 2,2,2,2,5,5,5,5 with no gap; o_done at cycle 11.
- i_start re-pulsed during RUN → ignored; done timing unchanged. i_rst_n low at cycle 10 → all outputs 0 and state IDLE with no o_done; a fresh start then runs a clean sweep.
- ERR_W=3, mask=0xFF, fault held → o_err_cnt saturates at 7 and stays at 7 through DONE.
